// File: rtl/conway_engine.sv
// conway_engine: Game-of-Life compute engine for a 2^LOG_W x 2^LOG_H board.
// Each cell takes 8 single-neighbour read cycles plus one commit cycle into a
// shadow board, which is then copied back to the visible board one cell per
// cycle. RANDOMIZE/CLEAR fill the board one cell per cycle.
module conway_engine #(
  parameter int          LOG_W        = 3,
  parameter int          LOG_H        = 3,
  parameter logic [8:0]  BIRTH_MASK   = 9'b000001000,
  parameter logic [8:0]  SURVIVE_MASK = 9'b000001100,
  parameter int          GEN_W        = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  input  logic [1:0]             cmd,
  input  logic                   wrap_mode,
  output logic                   cmd_ready,
  output logic                   busy,
  output logic                   done,
  input  logic                   rnd_bit,
  input  logic                   wr_en,
  input  logic [LOG_W+LOG_H-1:0] wr_addr,
  input  logic                   wr_data,
  input  logic [LOG_W+LOG_H-1:0] rd_addr,
  output logic                   rd_data,
  output logic [LOG_W+LOG_H:0]   population,
  output logic [GEN_W-1:0]       generation
);
  localparam int LOG_N = LOG_W + LOG_H;
  localparam int N     = 1 << LOG_N;
  localparam int PW    = LOG_N + 1;

  localparam logic [1:0] CMD_STEP  = 2'd0;
  localparam logic [1:0] CMD_RAND  = 2'd1;
  localparam logic [1:0] CMD_CLEAR = 2'd2;

  // Masks widened so the 4-bit count indexes them without range issues.
  localparam logic [15:0] BIRTH16   = {7'd0, BIRTH_MASK};
  localparam logic [15:0] SURVIVE16 = {7'd0, SURVIVE_MASK};

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_NEIGH, S_COMMIT, S_COPY, S_DONE
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [N-1:0]       r_cur;
  logic [N-1:0]       r_next;
  logic [LOG_N-1:0]   r_idx;
  logic [2:0]         r_nb;
  logic [3:0]         r_cnt;
  logic [PW-1:0]      r_pop;
  logic [GEN_W-1:0]   r_gen;
  logic [1:0]         r_cmd;
  logic               r_wrap;

  logic               w_accept;
  logic               w_idx_last;
  logic [1:0]         w_dx, w_dy;   // 0:-1, 1:0, 2:+1
  logic [LOG_W-1:0]   w_x, w_nx;
  logic [LOG_H-1:0]   w_y, w_ny;
  logic               w_off;
  logic               w_nval;
  logic               w_fill_bit;
  logic               w_new;
  logic               w_load_bit;

  assign w_accept   = cmd_valid & cmd_ready;
  assign w_idx_last = (r_idx == {LOG_N{1'b1}});
  assign w_x        = r_idx[LOG_W-1:0];
  assign w_y        = r_idx[LOG_N-1:LOG_W];
  assign w_fill_bit = (r_cmd == CMD_RAND) & rnd_bit;
  assign w_new      = r_cur[r_idx] ? SURVIVE16[r_cnt] : BIRTH16[r_cnt];
  assign w_load_bit = (r_state == S_COPY) ? r_next[r_idx] : w_fill_bit;

  assign rd_data    = r_cur[rd_addr];
  assign population = r_pop;
  assign generation = r_gen;

  // Neighbour offset for the current scan slot.
  always_comb begin
    w_dx = 2'd1;
    w_dy = 2'd1;
    case (r_nb)
      3'd0: begin w_dx = 2'd0; w_dy = 2'd2; end
      3'd1: begin w_dx = 2'd1; w_dy = 2'd2; end
      3'd2: begin w_dx = 2'd2; w_dy = 2'd2; end
      3'd3: begin w_dx = 2'd0; w_dy = 2'd1; end
      3'd4: begin w_dx = 2'd2; w_dy = 2'd1; end
      3'd5: begin w_dx = 2'd0; w_dy = 2'd0; end
      3'd6: begin w_dx = 2'd1; w_dy = 2'd0; end
      default: begin w_dx = 2'd2; w_dy = 2'd0; end
    endcase
  end

  // Neighbour address wraps naturally; off-board flag masks it in dead-edge mode.
  always_comb begin
    w_nx  = (w_dx == 2'd0) ? w_x - LOG_W'(1) : (w_dx == 2'd2) ? w_x + LOG_W'(1) : w_x;
    w_ny  = (w_dy == 2'd0) ? w_y - LOG_H'(1) : (w_dy == 2'd2) ? w_y + LOG_H'(1) : w_y;
    w_off = ((w_dx == 2'd0) && (w_x == '0)) || ((w_dx == 2'd2) && (w_x == '1)) ||
            ((w_dy == 2'd0) && (w_y == '0)) || ((w_dy == 2'd2) && (w_y == '1));
    w_nval = r_cur[{w_ny, w_nx}] & (r_wrap | ~w_off);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        done      = (r_state == S_DONE);
        if (cmd_valid) begin
          case (cmd)
            CMD_STEP:            w_state_nxt = S_NEIGH;
            CMD_RAND, CMD_CLEAR: w_state_nxt = S_FILL;
            default:             w_state_nxt = S_DONE;
          endcase
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FILL:   if (w_idx_last) w_state_nxt = S_DONE;
      S_NEIGH:  if (r_nb == 3'd7) w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = w_idx_last ? S_COPY : S_NEIGH;
      S_COPY:   if (w_idx_last) w_state_nxt = S_DONE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Board storage: host writes when ready, fill/commit/copy while busy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      case (r_state)
        S_IDLE, S_DONE: if (wr_en) r_cur[wr_addr] <= wr_data;
        S_FILL:         r_cur[r_idx]  <= w_fill_bit;
        S_COMMIT:       r_next[r_idx] <= w_new;
        S_COPY:         r_cur[r_idx]  <= r_next[r_idx];
        default: ;
      endcase
    end
  end

  // Scan counters, population and generation bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx  <= '0;
      r_nb   <= '0;
      r_cnt  <= '0;
      r_pop  <= '0;
      r_gen  <= '0;
      r_cmd  <= 2'd3;
      r_wrap <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if ((r_state == S_DONE) && (r_cmd == CMD_STEP)) r_gen <= r_gen + GEN_W'(1);
          if (wr_en) begin
            if (wr_data && !r_cur[wr_addr])      r_pop <= r_pop + PW'(1);
            else if (!wr_data && r_cur[wr_addr]) r_pop <= r_pop - PW'(1);
          end
          if (w_accept) begin
            r_cmd  <= cmd;
            r_wrap <= wrap_mode;
            r_idx  <= '0;
            r_nb   <= '0;
            r_cnt  <= '0;
          end
        end
        S_FILL, S_COPY: begin
          // Recount from scratch as cells are rewritten in address order.
          r_pop <= ((r_idx == '0) ? '0 : r_pop) + {{LOG_N{1'b0}}, w_load_bit};
          r_idx <= r_idx + LOG_N'(1);
          if (r_state == S_FILL) r_gen <= '0;
        end
        S_NEIGH: begin
          r_cnt <= r_cnt + {3'b000, w_nval};
          r_nb  <= r_nb + 3'd1;
        end
        S_COMMIT: begin
          r_cnt <= '0;
          r_idx <= r_idx + LOG_N'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/conway_engine.md
# conway_engine

Parametrised Game-of-Life compute engine that holds a WIDTH x HEIGHT board and advances it under a command handshake. It supports runtime-selectable toroidal or dead-edge boundaries, birth/survival rules set by parameters, and tracks a generation count and live-cell population. It sits between the UART/VGA front-ends and the board storage. The front-ends issue commands, load cells through the write port, and render the board through the asynchronous read port.

## Interface
- LOG_W, 3: log2 of board width; W = 2^LOG_W.
- LOG_H, 3: log2 of board height; H = 2^LOG_H; N = W*H; address = y*W + x.
- BIRTH_MASK, 9'b000001000: bit k set means a dead cell with k neighbours is born.
- SURVIVE_MASK, 9'b000001100: bit k set means a live cell with k neighbours survives.
- GEN_W, 16: generation counter width.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd  in  2  0 STEP, 1 RANDOMIZE, 2 CLEAR, 3 NOP.
- wrap_mode  in  1  1 = torus, 0 = off-board neighbours dead; sampled at command accept.
- cmd_ready  out  1  high when idle.
- busy  out  1  high while a command executes.
- done  out  1  one-cycle pulse at command completion.
- rnd_bit  in  1  random bit from the LFSR, consumed one per cell by RANDOMIZE.
- wr_en  in  1  single-cell write strobe.
- wr_addr  in  LOG_W+LOG_H  write cell address.
- wr_data  in  1  write cell value.
- rd_addr  in  LOG_W+LOG_H  read cell address.
- rd_data  out  1  combinational value of the current board at rd_addr.
- population  out  LOG_W+LOG_H+1  live-cell count of the current board.
- generation  out  GEN_W  number of STEPs completed since the last CLEAR, RANDOMIZE or reset.

## Operation
- States: IDLE, FILL (RANDOMIZE/CLEAR), NEIGH, COMMIT, COPY, DONE.
- Command accept: a command is accepted when cmd_valid & cmd_ready. The engine leaves IDLE on the next edge and latches cmd and wrap_mode.
- NEIGH: for each cell, 8 cycles, one neighbour per cycle, in the order (-1,+1),(0,+1),(+1,+1),(-1,0),(+1,0),(-1,-1),(0,-1),(+1,-1). The count accumulates in a 4-bit accumulator.
  - Torus mode: coordinates wrap modulo W/H.
  - Dead-edge mode: an off-board neighbour adds 0.
- COMMIT: 1 cycle. next[idx] = cur[idx] ? SURVIVE_MASK[count] : BIRTH_MASK[count]. Then clear the count, advance idx, and return to NEIGH. After idx = N-1, go to COPY.
- COPY: N cycles. cur[i] <= next[i]; population is recounted from the copied values.
- FILL: N cycles. cur[i] <= rnd_bit (RANDOMIZE) or 0 (CLEAR); population is recounted and generation is set to 0.
- NOP: goes straight to DONE.
- DONE: 1 cycle. done = 1 and cmd_ready = 1. A STEP increments generation here, modulo 2^GEN_W. The engine returns to IDLE.
- Write port: honoured only when cmd_ready = 1; ignored while busy.
  - A write in the accept cycle lands before the command's first read.
  - A write also updates population: +1 for a 0->1 change, -1 for a 1->0 change, no change when the value is equal.
- rd_data always reflects cur. During COPY/FILL it shows a partially updated board, so consumers sample it only while cmd_ready.
- cmd_valid during busy is held off (not dropped) by cmd_ready = 0.

## Timing
- Reset values: cmd_ready 1, busy 0, done 0, population 0, generation 0, state IDLE, idx 0. Board storage is not reset; contents are unspecified until the first CLEAR, RANDOMIZE or write.
- Reset mid-command aborts immediately to the reset values. No done pulse is produced.
- Cycle 0 is the accept cycle.
- STEP latency: NEIGH/COMMIT occupy cycles 1..9N, COPY occupies 9N+1..10N, done at 10N+1. For 8x8: done at cycle 641.
- RANDOMIZE/CLEAR latency: done at N+1 (65 for 8x8). NOP: done at cycle 1.
- busy is high from cycle 1 through the last work cycle; it is low in the done cycle.
- A new command may be accepted in the done cycle.

## Test plan
- Reset, CLEAR, then write cells at addresses 26,27,28 (row 3, x=2..4), then STEP in torus mode -> done at cycle 641; live cells exactly 19,27,35; population 3; generation 1. A second STEP restores 26,27,28 with generation 2.
- CLEAR, write addresses 7,0,1 (row 0, x=7,0,1), STEP with wrap_mode=1 -> live cells 56,0,8, population 3. Repeat from the same setup with wrap_mode=0 -> empty board, population 0.
- RANDOMIZE with rnd_bit driven as an alternating 1,0 pattern -> even addresses live; population 32; generation 0; done at cycle 65.
- With BIRTH_MASK=9'b000000100 and SURVIVE_MASK=0 (seeds rule), a 2-cell pair at 27,28 -> births at 19,20,35,36 only; population 4.
- Assert wr_en and hold cmd_valid during a STEP -> board and population unchanged by the write; the command is accepted only in the done cycle; cmd_ready is 0 throughout busy.
- Assert reset at cycle 300 of a STEP -> next cycle cmd_ready 1, busy 0, generation 0, population 0; no done pulse.
